rr_request_arbiter: RTL and testbench
=====================================

Name: rr_request_arbiter

Overview:
Round-robin arbiter that shares one downstream resource (a serial datapath slot) among 16 requesters. Request lines arrive on the same 16-bit split as the priority encoder (ui_in = req[7:0], uio_in = req[15:8]). Grant index is reported in the encoder's output code format: {4'b0, idx} when granted, 8'hF0 when idle. The block adds fairness, grant hold/release handshake and a hold timeout on top of plain priority encoding.

Parameters:
NREQ, 16, number of requesters (fixed 16 for this tapeout; IDXW must equal clog2(NREQ))
IDXW, 4, grant index width
MAX_HOLD, 15, max cycles a grant may be held before forced release; 0 disables timeout

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low blocks new grants and releases any current grant
req  input  NREQ  request lines, level-sensitive, bit i = requester i
done  input  1  owner finished; releases current grant
grant_valid  output  1  a grant is active
grant_idx  output  IDXW  index of current owner (0 when !grant_valid)
grant_onehot  output  NREQ  one-hot grant (all zero when !grant_valid)
grant_code  output  8  {4'b0, grant_idx} when grant_valid, else 8'hF0
timeout_pulse  output  1  one-cycle pulse on forced release by timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ptr=NREQ-1, hold_cnt=0; grant_valid=0, grant_idx=0, grant_onehot=0, grant_code=8'hF0, timeout_pulse=0. Reset mid-grant drops grant immediately (asynchronously).
- All outputs registered; no combinational path from req/done to outputs.
- States: IDLE, GRANT.
- IDLE: if ena=1 and req!=0 at edge, select winner, load grant regs, hold_cnt=0, go GRANT. Grant visible 1 cycle after req sampled. Otherwise stay IDLE.
- Winner selection: search order ptr+1, ptr+2, ..., ptr (mod NREQ); first set bit wins. After reset ptr=15, so index 0 has top priority initially.
- GRANT: release when any of: done=1; req[grant_idx]=0; ena=0; MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1. On release: ptr=grant_idx, outputs cleared to idle values, go IDLE. Else hold_cnt+=1 (saturating at MAX_HOLD-1).
- timeout_pulse=1 for the cycle after release only if release caused solely by timeout (done=0, req held, ena=1). Done and timeout same edge -> no pulse.
- Minimum one idle cycle (grant_code=8'hF0) between consecutive grants, even with other requests pending. Back-to-back same requester therefore takes 2 cycles of gap? No: exactly one cycle of grant_valid=0 between grants.
- Fairness: requester that just released has lowest priority for next selection; any continuously requesting requester is granted within NREQ-1 other grants.
- req changes on non-owner lines during GRANT are ignored until next IDLE evaluation.
- grant_onehot == (1 << grant_idx) whenever grant_valid=1; invariant checked by bench.

Test Plan:
- Reset: rst_n=0 with req=16'hFFFF -> grant_code=8'hF0, grant_valid=0; release rst_n, next edge -> grant_idx=0, grant_code=8'h00, grant_onehot=16'h0001.
- Round robin: req=16'h2A05 held, done pulsed 1 cycle after each grant -> owner sequence 0,2,9,11,13,0; one 8'hF0 cycle between each grant.
- Owner drop: grant to 3 (req=16'h0008), deassert req[3] -> grant_valid=0 next edge, timeout_pulse=0, ptr=3 (next req=16'h0009 grants 0).
- Timeout: MAX_HOLD=15, req=16'h8000 held, done=0 -> grant_idx=15 valid exactly 15 cycles, then released with timeout_pulse=1 for one cycle; regrant to 15 after one idle cycle.
- Simultaneous done+timeout on cycle 15 -> release, timeout_pulse=0. ena=0 during grant -> release next edge; ena=0 with req=16'hFFFF -> no grant issued.
- Async reset mid-grant (owner 7) -> grant_code=8'hF0 without clock edge; after release first grant goes to lowest set index.

Source files
------------

// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter: 16 level-sensitive requesters share one slot, with done/drop release and hold timeout.
// Latency: grant registered one cycle after the request is sampled; at least one idle cycle between grants.
// Backpressure: none; requesters hold req until granted, owner holds req until done or forced release.
module rr_request_arbiter #(
    parameter int NREQ     = 16,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [NREQ-1:0] grant_onehot,
    output logic [7:0]      grant_code,
    output logic            timeout_pulse
);

    // Hold counter only needs to reach MAX_HOLD-1.
    localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [7:0] IDLE_CODE = 8'hF0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] ptr, ptr_nxt;
    logic [HCW-1:0]  hold_cnt, hold_cnt_nxt;
    logic            grant_valid_nxt;
    logic [IDXW-1:0] grant_idx_nxt;
    logic [NREQ-1:0] grant_onehot_nxt;
    logic [7:0]      grant_code_nxt;
    logic            timeout_pulse_nxt;

    logic            win_found;
    logic [IDXW-1:0] win_idx;
    logic [IDXW-1:0] pos;
    logic            rel_other;
    logic            timeout_hit;

    // Rotating search from ptr+1 around to ptr; scanning from the far end lets the nearest set bit win.
    // NREQ is a power of two, so the IDXW-bit add wraps modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            pos = ptr + IDXW'(k);
            if (req[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
        end
    end

    // Release causes while a grant is held; timeout alone is what raises the pulse.
    always_comb begin
        rel_other   = done | ~req[grant_idx] | ~ena;
        timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt         = state;
        ptr_nxt           = ptr;
        hold_cnt_nxt      = hold_cnt;
        grant_valid_nxt   = grant_valid;
        grant_idx_nxt     = grant_idx;
        grant_onehot_nxt  = grant_onehot;
        grant_code_nxt    = grant_code;
        timeout_pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (ena && win_found) begin
                    state_nxt        = GRANT;
                    hold_cnt_nxt     = '0;
                    grant_valid_nxt  = 1'b1;
                    grant_idx_nxt    = win_idx;
                    grant_onehot_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
                    grant_code_nxt   = {{(8-IDXW){1'b0}}, win_idx};
                end
            end
            GRANT: begin
                if (rel_other || timeout_hit) begin
                    // Releasing owner becomes lowest priority for the next search.
                    state_nxt         = IDLE;
                    ptr_nxt           = grant_idx;
                    hold_cnt_nxt      = '0;
                    grant_valid_nxt   = 1'b0;
                    grant_idx_nxt     = '0;
                    grant_onehot_nxt  = '0;
                    grant_code_nxt    = IDLE_CODE;
                    timeout_pulse_nxt = timeout_hit & ~rel_other;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + HCW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= IDXW'(NREQ - 1);
            hold_cnt      <= '0;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            grant_onehot  <= '0;
            grant_code    <= IDLE_CODE;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            hold_cnt      <= hold_cnt_nxt;
            grant_valid   <= grant_valid_nxt;
            grant_idx     <= grant_idx_nxt;
            grant_onehot  <= grant_onehot_nxt;
            grant_code    <= grant_code_nxt;
            timeout_pulse <= timeout_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Bench for rr_request_arbiter: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts outputs one edge after inputs are applied.
// Backpressure: n/a.
module tb_rr_request_arbiter;

    localparam int MAX_HOLD = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] req = '0;
    logic        done = 1'b0;
    logic        grant_valid;
    logic [3:0]  grant_idx;
    logic [15:0] grant_onehot;
    logic [7:0]  grant_code;
    logic        timeout_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: owner (-1 = none), last releaser, cycles the grant has been visible.
    int m_owner = -1;
    int m_last  = 15;
    int m_held  = 0;
    bit m_pulse = 0;

    rr_request_arbiter #(.NREQ(16), .IDXW(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .req           (req),
        .done          (done),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .grant_onehot  (grant_onehot),
        .grant_code    (grant_code),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 15;
        m_held  = 0;
        m_pulse = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        bit other;
        bit to;
        if (m_owner < 0) begin
            m_pulse = 0;
            if (ena && req != 0) begin
                for (int k = 1; k <= 16; k++) begin
                    int i;
                    i = (m_last + k) % 16;
                    if (req[i]) begin
                        m_owner = i;
                        m_held  = 1;
                        break;
                    end
                end
            end
        end else begin
            other = done || !req[m_owner] || !ena;
            to    = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (other || to) begin
                m_pulse = to && !other;
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_pulse = 0;
                m_held++;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0]  e_idx;
        logic [15:0] e_oh;
        logic [7:0]  e_code;
        e_idx  = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        e_oh   = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        e_code = (m_owner >= 0) ? {4'd0, e_idx} : 8'hF0;
        check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check("grant_idx", 32'(grant_idx), 32'(e_idx));
        check("grant_onehot", 32'(grant_onehot), 32'(e_oh));
        check("grant_code", 32'(grant_code), 32'(e_code));
        check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    endtask

    // Apply inputs, take one edge, then compare 1ns after the edge.
    task automatic step(input logic [15:0] r, input logic d, input logic e);
        req  = r;
        done = d;
        ena  = e;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    // Assert reset away from a clock edge and release it before the next one.
    task automatic do_reset(input logic [15:0] r);
        req  = r;
        done = 1'b0;
        ena  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_code", 32'(grant_code), 32'h0000_00F0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    logic [7:0] rr_codes [11];
    int         vcount;
    bit         seen_pulse;
    logic [15:0] rreq;

    initial begin
        rr_codes = '{8'h00, 8'hF0, 8'h02, 8'hF0, 8'h09, 8'hF0, 8'h0B, 8'hF0, 8'h0D, 8'hF0, 8'h00};

        // Reset with everyone requesting; index 0 wins first.
        do_reset(16'hFFFF);
        step(16'hFFFF, 1'b0, 1'b1);
        check("first_grant_code", 32'(grant_code), 32'h0000_0000);
        check("first_grant_oh", 32'(grant_onehot), 32'h0000_0001);

        // Round robin with done one cycle after each grant.
        do_reset(16'h2A05);
        for (int i = 0; i < 11; i++) begin
            step(16'h2A05, (i % 2) == 1, 1'b1);
            check("rr_code", 32'(grant_code), 32'(rr_codes[i]));
        end

        // Owner drops its request; releaser goes to the back of the line.
        do_reset(16'h0008);
        step(16'h0008, 1'b0, 1'b1);
        check("drop_owner", 32'(grant_idx), 32'd3);
        step(16'h0000, 1'b0, 1'b1);
        check("drop_pulse", 32'(timeout_pulse), 32'd0);
        step(16'h0009, 1'b0, 1'b1);
        check("drop_next", 32'(grant_code), 32'h0000_0000);

        // Timeout: held for exactly MAX_HOLD cycles, one pulse, regrant after one idle cycle.
        do_reset(16'h8000);
        vcount = 0;
        seen_pulse = 0;
        for (int i = 0; i < 18; i++) begin
            step(16'h8000, 1'b0, 1'b1);
            if (grant_valid && !seen_pulse) vcount++;
            if (timeout_pulse) seen_pulse = 1;
        end
        check("timeout_len", 32'(vcount), 32'(MAX_HOLD));
        check("timeout_seen", 32'(seen_pulse), 32'd1);

        // Done on the timeout cycle suppresses the pulse.
        do_reset(16'h8000);
        for (int i = 0; i < MAX_HOLD; i++) step(16'h8000, 1'b0, 1'b1);
        step(16'h8000, 1'b1, 1'b1);
        check("done_to_pulse", 32'(timeout_pulse), 32'd0);

        // ena low releases, and blocks new grants.
        step(16'hFFFF, 1'b0, 1'b1);
        step(16'hFFFF, 1'b0, 1'b0);
        check("ena_release", 32'(grant_valid), 32'd0);
        step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b0, 1'b0);
        check("ena_block", 32'(grant_code), 32'h0000_00F0);

        // Async reset while owner 7 holds the grant.
        do_reset(16'h0080);
        step(16'h0080, 1'b0, 1'b1);
        check("pre_areset_idx", 32'(grant_idx), 32'd7);
        rst_n = 1'b0;
        #2;
        model_reset();
        check("areset_code", 32'(grant_code), 32'h0000_00F0);
        rst_n = 1'b1;
        step(16'h0A80, 1'b0, 1'b1);
        check("post_areset_idx", 32'(grant_idx), 32'd7);

        // Random traffic: sticky requests so timeouts and fairness get exercised.
        rreq = 16'h0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) rreq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(199) == 0) begin
                do_reset(rreq);
            end else begin
                step(rreq, $urandom_range(7) == 0, $urandom_range(15) != 0);
                if (grant_valid)
                    check("onehot_inv", 32'(grant_onehot), 32'(16'd1 << grant_idx));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
